// File: rtl/logic_unit_ctrl.sv
// Multicycle control FSM: fetch, decode, execute on ALU/AND/OR units, memory access, writeback.
// Control outputs decode combinationally from state, latched opcode, mem_ready and zero.
module logic_unit_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_en,
    output logic             alu_sub,
    output logic             and_en,
    output logic             or_en,
    output logic             reg_write,
    output logic             wb_src,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpAdd  = 4'h1;
    localparam logic [3:0] OpSub  = 4'h2;
    localparam logic [3:0] OpAnd  = 4'h3;
    localparam logic [3:0] OpOr   = 4'h4;
    localparam logic [3:0] OpLw   = 4'h5;
    localparam logic [3:0] OpSw   = 4'h6;
    localparam logic [3:0] OpBeq  = 4'h7;
    localparam logic [3:0] OpHalt = 4'hF;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        retired_d = retired_q;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        ir_write  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_en    = 1'b0;
        alu_sub   = 1'b0;
        and_en    = 1'b0;
        or_en     = 1'b0;
        reg_write = 1'b0;
        wb_src    = 1'b0;
        illegal   = 1'b0;
        halted    = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                // Decode straight from the IR output; op_q is only valid from EXEC on.
                op_d = opcode;
                case (opcode)
                    OpHalt: state_d = StHalt;
                    OpNop: begin
                        state_d   = StFetch;
                        retired_d = retired_q + CntOne;
                    end
                    OpAdd, OpSub, OpAnd, OpOr, OpLw, OpSw, OpBeq: state_d = StExec;
                    default: begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StExec: begin
                case (op_q)
                    OpAdd: begin
                        alu_en  = 1'b1;
                        state_d = StWb;
                    end
                    OpSub: begin
                        alu_en  = 1'b1;
                        alu_sub = 1'b1;
                        state_d = StWb;
                    end
                    OpAnd: begin
                        and_en  = 1'b1;
                        state_d = StWb;
                    end
                    OpOr: begin
                        or_en   = 1'b1;
                        state_d = StWb;
                    end
                    OpLw, OpSw: begin
                        alu_en  = 1'b1;
                        state_d = StMem;
                    end
                    OpBeq: begin
                        alu_en    = 1'b1;
                        alu_sub   = 1'b1;
                        pc_write  = zero;
                        pc_src    = zero;
                        state_d   = StFetch;
                        retired_d = retired_q + CntOne;
                    end
                    default: state_d = StFetch;
                endcase
            end
            StMem: begin
                mem_read  = (op_q == OpLw);
                mem_write = (op_q != OpLw);
                if (mem_ready) begin
                    if (op_q == OpLw) begin
                        state_d = StWb;
                    end else begin
                        state_d   = StFetch;
                        retired_d = retired_q + CntOne;
                    end
                end
            end
            StWb: begin
                reg_write = 1'b1;
                wb_src    = (op_q == OpLw);
                state_d   = StFetch;
                retired_d = retired_q + CntOne;
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= 4'h0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_logic_unit_ctrl.sv
// Randomized bench for logic_unit_ctrl: each instruction is expanded into its expected
// per-cycle control pattern and retired count, and compared cycle by cycle.
module tb_logic_unit_ctrl;

    localparam int unsigned CNT_W = 16;

    localparam logic [12:0] VPcw  = 13'h1000;
    localparam logic [12:0] VPcs  = 13'h0800;
    localparam logic [12:0] VIrw  = 13'h0400;
    localparam logic [12:0] VMrd  = 13'h0200;
    localparam logic [12:0] VMwr  = 13'h0100;
    localparam logic [12:0] VAlu  = 13'h0080;
    localparam logic [12:0] VSub  = 13'h0040;
    localparam logic [12:0] VAnd  = 13'h0020;
    localparam logic [12:0] VOr   = 13'h0010;
    localparam logic [12:0] VRegw = 13'h0008;
    localparam logic [12:0] VWbs  = 13'h0004;
    localparam logic [12:0] VIll  = 13'h0002;
    localparam logic [12:0] VHlt  = 13'h0001;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [3:0]       opcode = 4'h0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             pc_write, pc_src, ir_write, mem_read, mem_write;
    logic             alu_en, alu_sub, and_en, or_en, reg_write, wb_src, illegal, halted;
    logic [CNT_W-1:0] retired;

    int n_checks = 0;
    int n_errors = 0;
    int exp_ret  = 0;

    logic [12:0] dut_vec;
    assign dut_vec = {pc_write, pc_src, ir_write, mem_read, mem_write, alu_en, alu_sub,
                      and_en, or_en, reg_write, wb_src, illegal, halted};

    logic_unit_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .ir_write  (ir_write),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .alu_en    (alu_en),
        .alu_sub   (alu_sub),
        .and_en    (and_en),
        .or_en     (or_en),
        .reg_write (reg_write),
        .wb_src    (wb_src),
        .illegal   (illegal),
        .halted    (halted),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [3:0] r4();
        return 4'($urandom);
    endfunction

    // One clock cycle: drive inputs at negedge, check outputs and retired count before posedge.
    task automatic step(input logic st, input logic mr, input logic [3:0] opc, input logic z,
                        input logic [12:0] exp_v, input string tag);
        @(negedge clk);
        start     = st;
        mem_ready = mr;
        opcode    = opc;
        zero      = z;
        #2;
        check_val(tag, {19'd0, dut_vec}, {19'd0, exp_v});
        check_val({tag, "_retired"}, {16'd0, retired}, {16'd0, 16'(exp_ret)});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        start     = 1'b0;
        mem_ready = rb();
        @(negedge clk);
        reset = 1'b0;
        exp_ret = 0;
        #2;
        check_val("reset_vec", {19'd0, dut_vec}, 32'd0);
        check_val("reset_retired", {16'd0, retired}, 32'd0);
    endtask

    task automatic start_run();
        step(1'b0, rb(), r4(), rb(), 13'h0, "idle");
        step(1'b1, rb(), r4(), rb(), 13'h0, "idle_start");
    endtask

    task automatic fetch_decode(input logic [3:0] op, input int fw, input logic [12:0] dec_v);
        for (int i = 0; i < fw; i++) step(rb(), 1'b0, r4(), rb(), VMrd, "fetch_wait");
        step(rb(), 1'b1, r4(), rb(), VMrd | VIrw | VPcw, "fetch");
        step(rb(), rb(), op, rb(), dec_v, "decode");
    endtask

    task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input logic z);
        if (op == 4'hF) begin
            fetch_decode(op, fw, 13'h0);
            return;
        end
        if (op >= 4'h8) begin
            fetch_decode(op, fw, VIll);
            return;
        end
        fetch_decode(op, fw, 13'h0);
        case (op)
            4'h0: exp_ret++;
            4'h1: step(rb(), rb(), r4(), rb(), VAlu, "exec_add");
            4'h2: step(rb(), rb(), r4(), rb(), VAlu | VSub, "exec_sub");
            4'h3: step(rb(), rb(), r4(), rb(), VAnd, "exec_and");
            4'h4: step(rb(), rb(), r4(), rb(), VOr, "exec_or");
            4'h5, 4'h6: step(rb(), rb(), r4(), rb(), VAlu, "exec_addr");
            default: begin
                step(rb(), rb(), r4(), z, VAlu | VSub | (z ? (VPcw | VPcs) : 13'h0), "exec_beq");
                exp_ret++;
            end
        endcase
        if (op == 4'h5 || op == 4'h6) begin
            for (int i = 0; i < mw; i++)
                step(rb(), 1'b0, r4(), rb(), (op == 4'h5) ? VMrd : VMwr, "mem_wait");
            step(rb(), 1'b1, r4(), rb(), (op == 4'h5) ? VMrd : VMwr, "mem_done");
            if (op == 4'h6) exp_ret++;
        end
        if (op >= 4'h1 && op <= 4'h5) begin
            step(rb(), rb(), r4(), rb(), VRegw | ((op == 4'h5) ? VWbs : 13'h0), "wb");
            exp_ret++;
        end
    endtask

    initial begin
        do_reset();
        step(1'b0, rb(), r4(), rb(), 13'h0, "idle_hold");
        start_run();

        run_instr(4'h1, 0, 0, 1'b0);
        run_instr(4'h4, 0, 0, 1'b0);
        run_instr(4'h5, 0, 3, 1'b0);
        run_instr(4'h7, 0, 0, 1'b1);
        run_instr(4'h7, 0, 0, 1'b0);
        run_instr(4'hA, 0, 0, 1'b0);
        run_instr(4'h0, 0, 0, 1'b0);
        run_instr(4'h2, 1, 0, 1'b0);
        run_instr(4'h3, 2, 0, 1'b0);
        run_instr(4'h6, 0, 2, 1'b0);

        for (int n = 0; n < 150; n++)
            run_instr(4'($urandom_range(0, 14)), $urandom_range(0, 2), $urandom_range(0, 3), rb());

        // Abort a stalled SW store with reset; the request must drop immediately.
        fetch_decode(4'h6, 0, 13'h0);
        step(rb(), rb(), r4(), rb(), VAlu, "exec_sw_abort");
        step(rb(), 1'b0, r4(), rb(), VMwr, "mem_wait_abort");
        step(rb(), 1'b0, r4(), rb(), VMwr, "mem_wait_abort");
        do_reset();
        step(1'b0, 1'b1, r4(), rb(), 13'h0, "idle_after_abort");
        start_run();

        for (int n = 0; n < 80; n++)
            run_instr(4'($urandom_range(0, 14)), $urandom_range(0, 2), $urandom_range(0, 3), rb());

        run_instr(4'hF, 1, 0, 1'b0);
        for (int i = 0; i < 6; i++) step((i % 2) == 0, rb(), r4(), rb(), VHlt, "halted");

        do_reset();
        start_run();
        run_instr(4'h1, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
